seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan.sv
// seg_scan: eight-digit multiplexed seven-segment scanner.
// A prescaler sets the digit step rate; display data is double-buffered
// (pending -> shadow) and the shadow is swapped only when the scan wraps
// from digit 7 to digit 0, so a frame never shows a mix of old and new data.
// Optional build macro SEG_BLANK_EN enables leading-zero blanking.
module seg_scan #(
  parameter int         SCAN_DIV = 50000,
  parameter logic [7:0] DP_MASK  = 8'h00
) (
  input  logic        clk_board,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int            PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic [2:0]    digit_reg, digit_next;
  logic          run_reg, run_next;
  logic [31:0]   shadow_reg, shadow_next;
  logic [31:0]   pend_data_reg, pend_data_next;
  logic          pend_flag_reg, pend_flag_next;
  logic [7:0]    an_reg, an_next;
  logic [6:0]    seg_reg, seg_next;
  logic          dp_reg, dp_next;
  logic          frame_done_reg, frame_done_next;

  logic          step;
  logic          wrap;
  logic [3:0]    nib_arr [8];
  logic [3:0]    cur_nib;
  logic [6:0]    seg_dec;
  logic          digit_blank;

  // Split the (next) shadow word into nibbles, one per digit.
  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    assign nib_arr[gi] = shadow_next[4*gi +: 4];
  end

  // Scan timing and double-buffer control. run_reg stays low after reset
  // until the first full prescaler period, so digit 0 is first lit one
  // whole step after reset release rather than immediately.
  always_comb begin
    step            = (presc_reg == PRESC_LAST);
    presc_next      = step ? '0 : presc_reg + 1'b1;
    run_next        = run_reg | step;
    wrap            = step && run_reg && (digit_reg == 3'd7);
    digit_next      = digit_reg;
    shadow_next     = shadow_reg;
    pend_data_next  = pend_data_reg;
    pend_flag_next  = pend_flag_reg;
    frame_done_next = wrap;
    if (step && run_reg) begin
      digit_next = digit_reg + 3'd1;
    end
    if (wrap) begin
      // A load arriving exactly on the wrap goes straight to the shadow.
      if (data_valid) begin
        shadow_next = data;
      end else if (pend_flag_reg) begin
        shadow_next = pend_data_reg;
      end
      pend_flag_next = 1'b0;
    end else if (data_valid) begin
      pend_data_next = data;
      pend_flag_next = 1'b1;
    end
  end

`ifdef SEG_BLANK_EN
  logic [7:0] nz;
  logic [2:0] hi_idx;

  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz[gi] = |nib_arr[gi];
  end

  // Highest nonzero nibble; digits above it are blanked (digit 0 never is).
  always_comb begin
    hi_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (nz[k]) hi_idx = 3'(k);
    end
    digit_blank = (digit_next > hi_idx);
  end
`else
  // All digits are always driven.
  always_comb begin
    digit_blank = 1'b0;
  end
`endif

  // Hex to active-low segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    cur_nib = nib_arr[digit_next];
    seg_dec = 7'h7F;
    case (cur_nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  // Output drive derived from next-state values so the registered pins
  // change in the same cycle the digit index does.
  always_comb begin
    an_next  = 8'hFF;
    seg_next = 7'h7F;
    dp_next  = 1'b1;
    if (run_next && !digit_blank) begin
      an_next  = ~(8'h01 << digit_next);
      seg_next = seg_dec;
      dp_next  = ~DP_MASK[digit_next];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_board) begin
    if (rst) begin
      presc_reg      <= '0;
      digit_reg      <= 3'd0;
      run_reg        <= 1'b0;
      shadow_reg     <= 32'h0;
      pend_data_reg  <= 32'h0;
      pend_flag_reg  <= 1'b0;
      an_reg         <= 8'hFF;
      seg_reg        <= 7'h7F;
      dp_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      digit_reg      <= digit_next;
      run_reg        <= run_next;
      shadow_reg     <= shadow_next;
      pend_data_reg  <= pend_data_next;
      pend_flag_reg  <= pend_flag_next;
      an_reg         <= an_next;
      seg_reg        <= seg_next;
      dp_reg         <= dp_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign frame_done = frame_done_reg;

endmodule
